// File: rtl/fp_stream_accumulator.sv
// rtl/fp_stream_accumulator.sv - packet-wise IEEE-754 single stream summer with its adder

// Combinational single-precision adder, round-to-nearest-even, subnormals kept.
// Exponent-255 operands are not interpreted; overflow shows up as exponent 255.
module fp_adder (
  input  logic [31:0] a_i,
  input  logic [31:0] b_i,
  output logic [31:0] s_o
);
  logic        swap;
  logic [31:0] x, y;
  logic [7:0]  ex_eff, ey_eff, d;
  logic [23:0] mx, my;
  logic [26:0] x_al, y_sh, y_al, mask;
  logic        sticky;
  logic [27:0] sum;
  logic [26:0] m_pre, m_norm;
  logic [9:0]  e_pre, e_fin, shamt;
  logic [4:0]  lz;
  logic        round_up, zero, sgn;
  logic [30:0] packed_mag;

  // Order operands by magnitude so the magnitude subtraction never goes negative
  always_comb begin
    swap   = b_i[30:0] > a_i[30:0];
    x      = swap ? b_i : a_i;
    y      = swap ? a_i : b_i;
    mx     = {x[30:23] != 8'd0, x[22:0]};
    my     = {y[30:23] != 8'd0, y[22:0]};
    ex_eff = (x[30:23] == 8'd0) ? 8'd1 : x[30:23];
    ey_eff = (y[30:23] == 8'd0) ? 8'd1 : y[30:23];
    d      = ex_eff - ey_eff;
  end

  // Align the smaller operand; bits shifted out collapse into a sticky bit
  always_comb begin
    x_al   = {mx, 3'b000};
    y_sh   = {my, 3'b000};
    mask   = '0;
    sticky = 1'b0;
    if (d >= 8'd27) begin
      y_al = {26'd0, |my};
    end else begin
      mask   = (27'd1 << d) - 27'd1;
      sticky = |(y_sh & mask);
      y_al   = (y_sh >> d) | {26'd0, sticky};
    end
  end

  // Add or subtract magnitudes, then normalise without going below the subnormal scale
  always_comb begin
    if (x[31] == y[31]) sum = {1'b0, x_al} + {1'b0, y_al};
    else                sum = {1'b0, x_al} - {1'b0, y_al};
    zero  = (sum == 28'd0);
    lz    = 5'd27;
    shamt = '0;
    if (sum[27]) begin
      m_pre  = {sum[27:2], sum[1] | sum[0]};
      e_pre  = {2'b00, ex_eff} + 10'd1;
      m_norm = m_pre;
      e_fin  = e_pre;
    end else begin
      m_pre = sum[26:0];
      e_pre = {2'b00, ex_eff};
      for (int i = 0; i < 27; i++) begin
        if (m_pre[i]) lz = 5'(26 - i);
      end
      shamt  = ({5'd0, lz} < (e_pre - 10'd1)) ? {5'd0, lz} : (e_pre - 10'd1);
      m_norm = m_pre << shamt;
      e_fin  = e_pre - shamt;
    end
  end

  // Round to nearest even; a mantissa carry ripples into the exponent field
  always_comb begin
    round_up   = m_norm[2] & (m_norm[1] | m_norm[0] | m_norm[3]);
    packed_mag = {(m_norm[26] ? e_fin[7:0] : 8'd0), m_norm[25:3]} + {30'd0, round_up};
    sgn        = zero ? (x[31] & y[31]) : x[31];
    if (zero)                   s_o = {sgn, 31'd0};
    else if (e_fin >= 10'd255)  s_o = {sgn, 8'hFF, 23'd0};
    else                        s_o = {sgn, packed_mag};
  end
endmodule

// Stream front end: sums each packet in arrival order and holds the result until taken.
module fp_stream_accumulator #(
  parameter int          CNT_W = 16,
  parameter logic [31:0] QNAN  = 32'h7FC00000
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_data,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_data,
  output logic [CNT_W-1:0] out_count,
  output logic             out_special,
  input  logic             clear
);
  typedef enum logic [1:0] {EMPTY, ACCUM, HOLD} state_t;

  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  state_t           state_q;
  logic [31:0]      acc_q, sum_w, out_data_q;
  logic [CNT_W-1:0] cnt_q, cnt_inc, out_count_q;
  logic             special_q, in_ready_q, out_valid_q, out_special_q;
  logic             in_is_spec, sum_is_spec, spec_acc;

  fp_adder u_adder (
    .a_i (acc_q),
    .b_i (in_data),
    .s_o (sum_w)
  );

  assign in_is_spec  = (in_data[30:23] == 8'hFF);
  assign sum_is_spec = (sum_w[30:23] == 8'hFF);
  assign spec_acc    = special_q | in_is_spec | sum_is_spec;
  assign cnt_inc     = (&cnt_q) ? cnt_q : cnt_q + CNT_ONE;

  assign in_ready    = in_ready_q;
  assign out_valid   = out_valid_q;
  assign out_data    = out_data_q;
  assign out_count   = out_count_q;
  assign out_special = out_special_q;

  // Packet FSM: accumulate beats, then present the registered sum until it is taken
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= EMPTY;
      acc_q         <= '0;
      cnt_q         <= '0;
      special_q     <= 1'b0;
      in_ready_q    <= 1'b1;
      out_valid_q   <= 1'b0;
      out_data_q    <= '0;
      out_count_q   <= '0;
      out_special_q <= 1'b0;
    end else begin
      case (state_q)
        EMPTY: begin
          if (clear) begin
            acc_q     <= '0;
            cnt_q     <= '0;
            special_q <= 1'b0;
          end else if (in_valid) begin
            // First beat bypasses the adder so -0 and subnormals stay bit-exact
            acc_q     <= in_data;
            cnt_q     <= CNT_ONE;
            special_q <= in_is_spec;
            if (in_last) begin
              state_q       <= HOLD;
              in_ready_q    <= 1'b0;
              out_valid_q   <= 1'b1;
              out_data_q    <= in_is_spec ? QNAN : in_data;
              out_count_q   <= CNT_ONE;
              out_special_q <= in_is_spec;
            end else begin
              state_q <= ACCUM;
            end
          end
        end
        ACCUM: begin
          if (clear) begin
            state_q   <= EMPTY;
            acc_q     <= '0;
            cnt_q     <= '0;
            special_q <= 1'b0;
          end else if (in_valid) begin
            acc_q     <= sum_w;
            cnt_q     <= cnt_inc;
            special_q <= spec_acc;
            if (in_last) begin
              state_q       <= HOLD;
              in_ready_q    <= 1'b0;
              out_valid_q   <= 1'b1;
              out_data_q    <= spec_acc ? QNAN : sum_w;
              out_count_q   <= cnt_inc;
              out_special_q <= spec_acc;
            end
          end
        end
        HOLD: begin
          // clear is ignored here so a finished sum is never lost
          if (out_ready) begin
            state_q       <= EMPTY;
            acc_q         <= '0;
            cnt_q         <= '0;
            special_q     <= 1'b0;
            in_ready_q    <= 1'b1;
            out_valid_q   <= 1'b0;
            out_data_q    <= '0;
            out_count_q   <= '0;
            out_special_q <= 1'b0;
          end
        end
        default: begin
          state_q    <= EMPTY;
          in_ready_q <= 1'b1;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_fp_stream_accumulator.sv
// tb/tb_fp_stream_accumulator.sv - scoreboard bench for fp_stream_accumulator
module tb_fp_stream_accumulator;
  localparam int          CNT_W   = 4;
  localparam int          CNT_MAX = (1 << CNT_W) - 1;
  localparam logic [31:0] QNAN    = 32'h7FC00000;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             in_valid, in_ready, in_last, out_valid, out_ready, out_special, clear;
  logic [31:0]      in_data, out_data;
  logic [CNT_W-1:0] out_count;

  typedef struct {
    logic [31:0] d;
    int          c;
    bit          s;
  } exp_t;

  exp_t        expq[$];
  int          checks = 0;
  int          errors = 0;
  bit          rdy_auto = 1'b0;
  logic [31:0] q[$];

  always #5 clk = ~clk;

  fp_stream_accumulator #(.CNT_W(CNT_W), .QNAN(QNAN)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_data     (in_data),
    .in_last     (in_last),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_data    (out_data),
    .out_count   (out_count),
    .out_special (out_special),
    .clear       (clear)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, req);
    end
  endtask

  // Exact reference: value = mag * 2^-149, summed exactly then rounded once
  function automatic logic [289:0] to_mag(input logic [31:0] v);
    logic [289:0] r;
    r = {266'd0, (v[30:23] != 8'd0), v[22:0]};
    if (v[30:23] != 8'd0) r = r << (v[30:23] - 8'd1);
    return r;
  endfunction

  function automatic logic [30:0] round_mag(input logic [289:0] m);
    int p, sh, e;
    logic [289:0] keep, rem, half;
    p = 0;
    for (int i = 0; i < 290; i++) if (m[i]) p = i;
    if (p <= 23) return m[30:0];
    sh   = p - 23;
    keep = m >> sh;
    rem  = m - (keep << sh);
    half = 290'd1 << (sh - 1);
    if (rem > half || (rem == half && keep[0])) keep = keep + 290'd1;
    if (keep[24]) begin
      keep = keep >> 1;
      sh++;
    end
    e = sh + 1;
    if (e >= 255) return 31'h7F800000;
    return {8'(e), keep[22:0]};
  endfunction

  function automatic logic [31:0] ref_add(input logic [31:0] a, input logic [31:0] b);
    logic [289:0] ma, mb, m;
    logic s;
    ma = to_mag(a);
    mb = to_mag(b);
    if (a[31] == b[31]) begin m = ma + mb; s = a[31]; end
    else if (ma >= mb)  begin m = ma - mb; s = a[31]; end
    else                begin m = mb - ma; s = b[31]; end
    if (m == 0) return {a[31] & b[31], 31'd0};
    return {s, round_mag(m)};
  endfunction

  function automatic exp_t model(input logic [31:0] b[$]);
    exp_t r;
    logic [31:0] acc;
    bit sp;
    acc = b[0];
    sp  = (b[0][30:23] == 8'hFF);
    for (int i = 1; i < b.size(); i++) begin
      if (b[i][30:23] == 8'hFF) sp = 1'b1;
      if (!sp) begin
        acc = ref_add(acc, b[i]);
        if (acc[30:23] == 8'hFF) sp = 1'b1;
      end
    end
    r.d = sp ? QNAN : acc;
    r.c = (b.size() > CNT_MAX) ? CNT_MAX : b.size();
    r.s = sp;
    return r;
  endfunction

  function automatic logic [31:0] rnd_op();
    int r;
    logic [7:0] e;
    r = $urandom_range(0, 99);
    if (r < 3)       e = 8'hFF;
    else if (r < 13) e = 8'h00;
    else if (r < 16) e = 8'hFE;
    else             e = 8'($urandom_range(110, 140));
    return {1'($urandom_range(0, 1)), e, 23'($urandom)};
  endfunction

  // Consumer side: random out_ready when enabled
  always @(posedge clk) begin
    #1;
    if (rdy_auto) out_ready = ($urandom_range(0, 3) != 0);
  end

  // Monitor: every output handshake pops one expected result
  always @(negedge clk) begin
    exp_t e;
    if (rst_n && out_valid && out_ready) begin
      if (expq.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_output: got %h expected none", out_data);
      end else begin
        e = expq.pop_front();
        check("out_data", out_data, e.d);
        check("out_count", 32'(out_count), 32'(e.c));
        check("out_special", 32'(out_special), 32'(e.s));
      end
    end
  end

  task automatic send_beat(input logic [31:0] d, input bit last, input int gap);
    int n;
    in_valid = 1'b0;
    repeat (gap) begin @(posedge clk); #1; end
    in_valid = 1'b1;
    in_data  = d;
    in_last  = last;
    n = 0;
    while (!in_ready && n < 500) begin @(posedge clk); #1; n++; end
    if (!in_ready) begin
      checks++;
      errors++;
      $display("FAIL in_ready_timeout: got 0 expected 1");
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic send_packet(input logic [31:0] b[$], input bit push, input exp_t e, input int maxgap);
    if (push) expq.push_back(e);
    for (int i = 0; i < b.size(); i++)
      send_beat(b[i], (i == b.size() - 1), $urandom_range(0, maxgap));
    check("latency_out_valid", 32'(out_valid), 32'd1);
  endtask

  task automatic run_dir(input logic [31:0] b[$], input logic [31:0] d, input int c, input bit s);
    exp_t e;
    e.d = d;
    e.c = c;
    e.s = s;
    send_packet(b, 1'b1, e, 1);
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while (expq.size() != 0 && n < 2000) begin @(posedge clk); #1; n++; end
    check("drain_timeout", 32'(expq.size()), 32'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    exp_t e;
    int   len;
    rst_n = 1'b0; in_valid = 1'b0; in_data = '0; in_last = 1'b0; out_ready = 1'b0; clear = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_data", out_data, 32'd0);
    check("rst_out_count", 32'(out_count), 32'd0);
    check("rst_out_special", 32'(out_special), 32'd0);
    @(posedge clk); #1;

    // Directed packets from the documented cases
    rdy_auto = 1'b1;
    q = '{32'h440d491c, 32'h4d064db7};             run_dir(q, 32'h4d064dda, 2, 0);
    q = '{32'h40000000, 32'h34000000, 32'h34000000}; run_dir(q, 32'h40000000, 3, 0);
    q = '{32'h34000000, 32'h34000000, 32'h40000000}; run_dir(q, 32'h40000001, 3, 0);
    q = '{32'h3F800001, 32'hBF800001};             run_dir(q, 32'h00000000, 2, 0);
    q = '{32'h00012832, 32'h8014283c};             run_dir(q, 32'h8013000a, 2, 0);
    q = '{32'h80000000};                           run_dir(q, 32'h80000000, 1, 0);
    q = '{32'h3F800000, 32'h7F800000, 32'h3F800000}; run_dir(q, QNAN, 3, 1);
    q = '{32'h7F7FFFFF, 32'h7F7FFFFF};             run_dir(q, QNAN, 2, 1);
    q.delete();
    for (int i = 0; i < 18; i++) q.push_back(32'h3F800000);
    run_dir(q, 32'h41900000, CNT_MAX, 0);
    wait_drain();

    // Backpressure: result held, input blocked
    rdy_auto = 1'b0; out_ready = 1'b0;
    q = '{32'h3F800000};
    run_dir(q, 32'h3F800000, 1, 0);
    in_valid = 1'b1; in_data = 32'h40400000; in_last = 1'b1;
    for (int i = 0; i < 5; i++) begin
      check("bp_in_ready", 32'(in_ready), 32'd0);
      check("bp_out_valid", 32'(out_valid), 32'd1);
      check("bp_out_data", out_data, 32'h3F800000);
      check("bp_out_count", 32'(out_count), 32'd1);
      @(posedge clk); #1;
    end
    in_valid = 1'b0; in_last = 1'b0; out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check("bp_released_valid", 32'(out_valid), 32'd0);
    check("bp_released_ready", 32'(in_ready), 32'd1);
    rdy_auto = 1'b1;
    q = '{32'h440d491c, 32'h4d064db7};             run_dir(q, 32'h4d064dda, 2, 0);
    wait_drain();

    // clear in ACCUM drops the partial sum and the beat presented with it
    send_beat(32'h3F800000, 1'b0, 0);
    send_beat(32'h40000000, 1'b0, 0);
    clear = 1'b1; in_valid = 1'b1; in_data = 32'h41000000; in_last = 1'b1;
    @(posedge clk); #1;
    clear = 1'b0; in_valid = 1'b0; in_last = 1'b0;
    check("clear_in_ready", 32'(in_ready), 32'd1);
    check("clear_out_valid", 32'(out_valid), 32'd0);
    q = '{32'h40000000};                           run_dir(q, 32'h40000000, 1, 0);
    wait_drain();

    // clear in HOLD is ignored
    rdy_auto = 1'b0; out_ready = 1'b0;
    q = '{32'h3F800000, 32'h3F800000};             run_dir(q, 32'h40000000, 2, 0);
    clear = 1'b1;
    @(posedge clk); #1;
    clear = 1'b0;
    check("hold_clear_valid", 32'(out_valid), 32'd1);
    check("hold_clear_data", out_data, 32'h40000000);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;

    // Asynchronous reset while holding a result
    e.d = '0; e.c = 0; e.s = 1'b0;
    q = '{32'h40000000, 32'h3F800000};
    send_packet(q, 1'b0, e, 0);
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_out_valid", 32'(out_valid), 32'd0);
    check("arst_in_ready", 32'(in_ready), 32'd1);
    check("arst_out_count", 32'(out_count), 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    rdy_auto = 1'b1;
    q = '{32'h80000000};                           run_dir(q, 32'h80000000, 1, 0);
    wait_drain();

    // Randomised packets against the exact-arithmetic reference
    for (int p = 0; p < 60; p++) begin
      len = ($urandom_range(0, 9) == 0) ? $urandom_range(15, 20) : $urandom_range(1, 6);
      q.delete();
      for (int k = 0; k < len; k++) q.push_back(rnd_op());
      send_packet(q, 1'b1, model(q), 2);
    end
    wait_drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
